// File: rtl/stack_ctrl.sv
// stack_ctrl - game-loop controller for the block stacker.
// Sequences plot -> delay -> erase -> update over a BLK_W x BLK_H block,
// scans the pixel offsets itself, owns the per-level move delay (halved
// each level), latches stop requests, locks blocks and flags completion.
// Optional feature: define STACK_CTRL_LEDR_EN to add the one-hot ledr port.
module stack_ctrl #(
  parameter int BLK_W      = 4,
  parameter int BLK_H      = 4,
  parameter int DELAY_BASE = 50000000,
  parameter int LEVELS     = 8,
  parameter int CNT_W      = 26
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       go,
  input  logic                                       stop_req,
  output logic [((BLK_W > 1) ? $clog2(BLK_W) : 1)-1:0] pix_x,
  output logic [((BLK_H > 1) ? $clog2(BLK_H) : 1)-1:0] pix_y,
  output logic                                       writeEn,
  output logic                                       colour_erase_enable,
  output logic                                       ld_xy,
  output logic                                       lock,
  output logic [$clog2(LEVELS+1)-1:0]                level,
  output logic                                       game_done
`ifdef STACK_CTRL_LEDR_EN
  ,
  output logic [9:0]                                 ledr
`endif
);

  localparam int XW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int YW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int LW = $clog2(LEVELS + 1);

  localparam logic [XW-1:0]    X_LAST   = XW'(BLK_W - 1);
  localparam logic [YW-1:0]    Y_LAST   = YW'(BLK_H - 1);
  localparam logic [LW-1:0]    LVL_END  = LW'(LEVELS);
  localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(DELAY_BASE);

  // Encoding order doubles as the ledr bit index.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_IDLE_WAIT  = 4'd1,
    S_PLOT       = 4'd2,
    S_LOAD_DELAY = 4'd3,
    S_COUNT      = 4'd4,
    S_CHECK      = 4'd5,
    S_ERASE      = 4'd6,
    S_UPDATE     = 4'd7,
    S_LOCK       = 4'd8,
    S_DONE       = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [XW-1:0]    r_px;
  logic [YW-1:0]    r_py;
  logic [CNT_W-1:0] r_cnt;
  logic [LW-1:0]    r_level;
  logic             r_pend;
  logic             w_last_pix;
  logic             w_scan;
  logic             w_stop_window;
  logic [LW-1:0]    w_level_inc;
  logic [CNT_W-1:0] w_delay;

  assign w_last_pix    = (r_px == X_LAST) && (r_py == Y_LAST);
  assign w_scan        = (r_state == S_PLOT) || (r_state == S_ERASE);
  assign w_stop_window = (r_state == S_PLOT) || (r_state == S_LOAD_DELAY) ||
                         (r_state == S_COUNT) || (r_state == S_CHECK) ||
                         (r_state == S_ERASE) || (r_state == S_UPDATE);
  assign w_level_inc   = r_level + 1'b1;

  assign pix_x = r_px;
  assign pix_y = r_py;
  assign level = r_level;

  // Move delay for the current level; deep levels saturate at one cycle.
  always_comb begin
    w_delay = BASE_CNT >> r_level;
    if (w_delay == '0) w_delay = CNT_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next              = r_state;
    writeEn             = 1'b0;
    colour_erase_enable = 1'b0;
    ld_xy               = 1'b0;
    lock                = 1'b0;
    game_done           = 1'b0;
    case (r_state)
      S_IDLE:       if (go) w_next = S_IDLE_WAIT;
      S_IDLE_WAIT:  if (!go) w_next = S_PLOT;
      S_PLOT: begin
        writeEn = 1'b1;
        if (w_last_pix) w_next = S_LOAD_DELAY;
      end
      S_LOAD_DELAY: w_next = S_COUNT;
      S_COUNT:      if (r_pend || (r_cnt <= CNT_W'(1))) w_next = S_CHECK;
      S_CHECK:      w_next = r_pend ? S_LOCK : S_ERASE;
      S_ERASE: begin
        writeEn             = 1'b1;
        colour_erase_enable = 1'b1;
        if (w_last_pix) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        ld_xy  = 1'b1;
        w_next = S_PLOT;
      end
      S_LOCK: begin
        lock   = 1'b1;
        w_next = (w_level_inc == LVL_END) ? S_DONE : S_PLOT;
      end
      S_DONE: begin
        game_done = 1'b1;
        if (go) w_next = S_IDLE_WAIT;
      end
      default:      w_next = S_IDLE;
    endcase
  end

  // Row-major pixel scan (x fastest) during PLOT/ERASE; parked at 0 otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_px <= '0;
      r_py <= '0;
    end else if (w_scan) begin
      if (r_px == X_LAST) begin
        r_px <= '0;
        r_py <= (r_py == Y_LAST) ? '0 : r_py + 1'b1;
      end else begin
        r_px <= r_px + 1'b1;
      end
    end else begin
      r_px <= '0;
      r_py <= '0;
    end
  end

  // Delay counter: loaded in LOAD_DELAY, counts down through COUNT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   r_cnt <= '0;
    else if (r_state == S_LOAD_DELAY)              r_cnt <= w_delay;
    else if ((r_state == S_COUNT) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
  end

  // Stop latch and level: lock consumes the stop and advances the level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend  <= 1'b0;
      r_level <= '0;
    end else if (r_state == S_LOCK) begin
      r_pend  <= 1'b0;
      r_level <= w_level_inc;
    end else begin
      if (stop_req && w_stop_window) r_pend <= 1'b1;
      if ((r_state == S_DONE) && go) r_level <= '0;
    end
  end

`ifdef STACK_CTRL_LEDR_EN
  // One-hot state debug for the board LEDs.
  always_comb begin
    ledr = 10'(1) << r_state;
  end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl with BLK_W=2, BLK_H=2, DELAY_BASE=8, LEVELS=3.
// Moves are predicted from a timing model of the game loop: plot, delay of
// D = max(8>>level,1) cycles, erase, update, with stop handling resolved
// arithmetically from the cycle at which the stop key is pressed.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic       stop_req;
  logic [0:0] pix_x;
  logic [0:0] pix_y;
  logic       writeEn;
  logic       colour_erase_enable;
  logic       ld_xy;
  logic       lock;
  logic [1:0] level;
  logic       game_done;

  int n_cmp = 0;
  int n_err = 0;
  int m_level = 0;
  bit m_pend = 1'b0;
  int move_no = 0;

  always #5 clk = ~clk;

  stack_ctrl #(
    .BLK_W(2), .BLK_H(2), .DELAY_BASE(8), .LEVELS(3), .CNT_W(8)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .stop_req(stop_req),
    .pix_x(pix_x), .pix_y(pix_y), .writeEn(writeEn),
    .colour_erase_enable(colour_erase_enable), .ld_xy(ld_xy),
    .lock(lock), .level(level), .game_done(game_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input int exp_level, input bit exp_done);
    chk({tag, " we"},    32'(writeEn), 32'(0));
    chk({tag, " erase"}, 32'(colour_erase_enable), 32'(0));
    chk({tag, " ld_xy"}, 32'(ld_xy), 32'(0));
    chk({tag, " lock"},  32'(lock), 32'(0));
    chk({tag, " pix_x"}, 32'(pix_x), 32'(0));
    chk({tag, " pix_y"}, 32'(pix_y), 32'(0));
    chk({tag, " level"}, 32'(level), 32'(exp_level));
    chk({tag, " done"},  32'(game_done), 32'(exp_done));
  endtask

  // One move starting at the first PLOT cycle. k = cycle (from move start)
  // in which stop_req is pulsed, or -1 for none.
  task automatic run_move(input int k);
    int d, ke, lock_at, len, ex, idx;
    bit drawing, erasing;
    string t;
    d = 8 >> m_level;
    if (d == 0) d = 1;
    ke = m_pend ? 0 : k;
    lock_at = -1;
    if (ke >= 0 && ke <= 4 + d) begin
      ex = (ke + 1 < 5) ? 5 : ke + 1;
      if (ex > 4 + d) ex = 4 + d;
      lock_at = ex + 2;
    end
    len = (lock_at >= 0) ? lock_at + 1 : 11 + d;
    move_no++;
    for (int c = 0; c < len; c++) begin
      t = $sformatf("move%0d c%0d", move_no, c);
      erasing = (lock_at < 0) && (c >= 6 + d) && (c <= 9 + d);
      drawing = (c < 4) || erasing;
      idx = (c < 4) ? c : c - (6 + d);
      chk({t, " we"},    32'(writeEn), 32'(drawing));
      chk({t, " erase"}, 32'(colour_erase_enable), 32'(erasing));
      chk({t, " ld_xy"}, 32'(ld_xy), 32'((lock_at < 0) && (c == 10 + d)));
      chk({t, " lock"},  32'(lock), 32'(c == lock_at));
      chk({t, " pix_x"}, 32'(pix_x), drawing ? 32'(idx % 2) : 32'(0));
      chk({t, " pix_y"}, 32'(pix_y), drawing ? 32'(idx / 2) : 32'(0));
      chk({t, " level"}, 32'(level), 32'(m_level));
      chk({t, " done"},  32'(game_done), 32'(0));
      stop_req = (c == k);
      tick();
    end
    stop_req = 1'b0;
    if (lock_at >= 0) begin
      m_level++;
      m_pend = 1'b0;
    end else if (k >= 5 + d) begin
      m_pend = 1'b1;
    end
  endtask

  // From DONE: press and release go, expect level cleared and PLOT next.
  task automatic restart_from_done();
    chk_quiet("done", 3, 1'b1);
    go = 1'b1;
    tick();
    chk_quiet("restart idle_wait", 0, 1'b0);
    go = 1'b0;
    tick();
    m_level = 0;
    m_pend  = 1'b0;
  endtask

  initial begin
    int k, d, guard;
    resetn   = 1'b0;
    go       = 1'b0;
    stop_req = 1'b0;
    tick();
    tick();
    chk_quiet("reset", 0, 1'b0);
    resetn = 1'b1;
    tick();
    chk_quiet("idle", 0, 1'b0);

    // Start: go held three cycles, PLOT one cycle after release.
    go = 1'b1;
    tick();
    tick();
    tick();
    go = 1'b0;
    chk_quiet("idle_wait", 0, 1'b0);
    tick();

    // Directed game.
    run_move(-1);           // full move, D=8, period 19
    run_move(7);            // stop pulsed in COUNT -> lock, level 1
    run_move(-1);           // D=4
    run_move(6 + 4 + 1);    // stop during ERASE -> erase completes
    run_move(-1);           // pending stop: COUNT 1 cycle, lock -> level 2
    run_move(3);            // stop in PLOT -> lock -> DONE
    tick();
    restart_from_done();

    // Randomised game.
    guard = 0;
    while (m_level < 3) begin
      d = 8 >> m_level;
      if (guard >= 30)                   k = 0;
      else if ($urandom_range(0, 3) == 0) k = -1;
      else                               k = int'($urandom_range(0, 10 + d));
      run_move(k);
      guard++;
    end
    tick();
    restart_from_done();

    // Reset during the third PLOT cycle.
    chk("rst plot c0 we", 32'(writeEn), 32'(1));
    tick();
    tick();
    chk("rst plot c2 we", 32'(writeEn), 32'(1));
    chk("rst plot c2 py", 32'(pix_y), 32'(1));
    resetn = 1'b0;
    #1;
    chk_quiet("async reset", 0, 1'b0);
    #2;
    resetn = 1'b1;
    tick();
    tick();
    tick();
    chk_quiet("idle after reset", 0, 1'b0);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    m_level = 0;
    m_pend  = 1'b0;
    run_move(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Parametrised game-loop controller for the block stacker, the successor to the single-level plot/erase FSM. It sequences plot → delay → erase → update for a BLK_W×BLK_H pixel block and generates the pixel-offset scan internally, so the datapath no longer needs a separate x/y counter. It also owns the per-level move delay, which halves at each level. It latches stop requests, locks the block on a stop, advances the level, and flags game completion. It sits between the key inputs and the VGA datapath/load module.

## Interface
- BLK_W, 4, block width in pixels (≥1)
- BLK_H, 4, block height in pixels (≥1)
- DELAY_BASE, 50000000, COUNT-state length in cycles at level 0
- LEVELS, 8, number of rows/levels to complete the game (≥1)
- CNT_W, 26, delay counter width (must hold DELAY_BASE)
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  reset; one clock, asynchronous assert, active-low
- go  in  1  start key, active-high; start fires on release
- stop_req  in  1  stop key, active-high, any length ≥1 cycle
- pix_x  out  $clog2(BLK_W) (min 1)  x offset within block
- pix_y  out  $clog2(BLK_H) (min 1)  y offset within block
- writeEn  out  1  VGA write strobe
- colour_erase_enable  out  1  selects background colour
- ld_xy  out  1  one-cycle strobe: load module advances block position
- lock  out  1  one-cycle strobe: block frozen, datapath starts next row
- level  out  $clog2(LEVELS+1)  current level, 0-based
- game_done  out  1  high while in DONE
- ledr  out  10  one-hot state debug (only with STACK_CTRL_LEDR_EN)

## Operation
- States: IDLE, IDLE_WAIT, PLOT, LOAD_DELAY, COUNT, CHECK, ERASE, UPDATE, LOCK, DONE.
- IDLE: go=1 → IDLE_WAIT. IDLE_WAIT: go=0 → PLOT.
- PLOT: writeEn=1. pix_x/pix_y scan row-major with x fastest, from (0,0). At (BLK_W-1,BLK_H-1), next state is LOAD_DELAY and the offsets clear to 0.
- LOAD_DELAY: loads the delay counter with D = DELAY_BASE>>level. If that value is 0, D=1. Next state is COUNT.
- COUNT: decrements the counter. Exits to CHECK when the counter reaches its final cycle or stop_pend=1. A full COUNT lasts exactly D cycles. If stop_pend=1 on entry, COUNT lasts 1 cycle.
- CHECK: stop_pend → LOCK, else → ERASE.
- ERASE: writeEn=1 and colour_erase_enable=1. Same scan as PLOT. After the last pixel, next state is UPDATE.
- UPDATE: ld_xy=1, then → PLOT.
- LOCK: lock=1. level increments and stop_pend clears. The block stays drawn. If the new level == LEVELS → DONE, else → PLOT.
- DONE: game_done=1. go=1 → IDLE_WAIT, and level clears to 0 on that transition.
- stop_pend: set by stop_req=1 in PLOT, LOAD_DELAY, COUNT, CHECK, ERASE or UPDATE. Ignored in IDLE, IDLE_WAIT and DONE. Cleared only in LOCK. A stop seen during ERASE does not abort the erase; it is honoured at the next CHECK.
- stop_req=1 in the LOCK cycle is ignored, so a held stop key locks one block only. A stop key held continuously re-arms the flag in the following PLOT.

## Timing
- Moore outputs decoded from the registered state. pix_x and pix_y are registered and valid in the same cycle as writeEn.
- Reset (asynchronous) forces IDLE, level=0, offsets=0, counter=0 and stop_pend=0. All outputs are 0, and ledr=10'b1 (IDLE bit).
- A reset assertion mid-PLOT, mid-ERASE or mid-COUNT takes effect immediately. No partial strobe follows.
- go release → first PLOT cycle: 1 cycle after the IDLE_WAIT edge.
- Move period without a stop: 2·BLK_W·BLK_H + D + 3 cycles.

## Configuration
- STACK_CTRL_LEDR_EN defined: the ledr port exists.
  - Bit mapping: IDLE=0, IDLE_WAIT=1, PLOT=2, LOAD_DELAY=3, COUNT=4, CHECK=5, ERASE=6, UPDATE=7, LOCK=8, DONE=9.
  - Exactly one bit is high.
- Not defined: no ledr port and no decode logic. All other behaviour is identical.

## Test plan
Parameters for all scenarios: BLK_W=2, BLK_H=2, DELAY_BASE=8, LEVELS=3.
- Start: go high for 3 cycles, then low → PLOT one cycle later.
  - writeEn high for 4 cycles with (pix_x,pix_y) = (0,0),(1,0),(0,1),(1,1).
- No stop:
  - COUNT lasts 8 cycles.
  - ERASE lasts 4 cycles with colour_erase_enable=1.
  - ld_xy pulses once.
  - PLOT restarts; the period is 19 cycles.
- stop_req pulsed for 1 cycle in COUNT at level 0:
  - CHECK, then LOCK with lock=1 for 1 cycle and level=1.
  - No ERASE occurs.
  - The following COUNT lasts 4 cycles.
- stop_req pulsed during ERASE:
  - The erase completes and ld_xy pulses.
  - PLOT follows, then COUNT for 1 cycle, then LOCK.
- Three locks → level=3 and game_done=1.
  - Then go high and released → level=0 and PLOT restarts.
- resetn low during the 3rd PLOT cycle:
  - writeEn=0 and pix_x=pix_y=0 at once.
  - State is IDLE; after release, go is required to restart.
